// File: rtl/hit_diag_filter_if.sv
// Hit stream bundle: serialized input hits plus the valid/ready head of the output FIFO.
// The slave modport is the filter's view; the master modport is the producer/consumer side.
interface hit_diag_filter_if #(
  parameter int W = 8
);
  logic [W-1:0] hit_add_inQ;
  logic [W-1:0] hit_add_inS;
  logic [W-1:0] hit_length;
  logic [W-1:0] hit_q_out;
  logic [W-1:0] hit_s_out;
  logic [W-1:0] hit_len_out;
  logic         out_valid;
  logic         out_ready;

  modport slave (
    input  hit_add_inQ, hit_add_inS, hit_length, out_ready,
    output hit_q_out, hit_s_out, hit_len_out, out_valid
  );

  modport master (
    output hit_add_inQ, hit_add_inS, hit_length, out_ready,
    input  hit_q_out, hit_s_out, hit_len_out, out_valid
  );
endinterface

// File: rtl/hit_diag_filter.sv
// Drops hits already covered on their diagonal; survivors reach out_valid 2 cycles after input.
// No input backpressure; output is valid/ready and a push into a full FIFO is lost and sets overflow.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic             lost
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             pop;
  logic             push_ok;

  assign out_vld = (count != '0);
  assign out_dat = out_vld ? mem[rd_ptr] : '0;
  assign pop     = out_vld && out_rdy;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign push_ok = in_vld && ((count < (AW+1)'(DEPTH)) || pop);
  assign lost    = in_vld && !push_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push_ok) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= in_dat;
  end
endmodule

module hit_diag_filter #(
  parameter int LENGTH_COUNTER = 8,
  parameter int TABLE_DEPTH    = 8,
  parameter int OUT_DEPTH      = 4
) (
  input  logic               com_clk,
  input  logic               reset,
  hit_diag_filter_if.slave   hit,
  output logic               overflow,
  output logic [15:0]        pass_count,
  output logic [15:0]        drop_count
);
  localparam int W  = LENGTH_COUNTER;
  localparam int TW = $clog2(TABLE_DEPTH);

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] s;
    logic [W-1:0] len;
  } hit_t;

  hit_t s1_hit;
  logic s1_vld;

  always_ff @(posedge com_clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_hit <= '0;
    end else begin
      s1_vld <= (hit.hit_length != '0);
      s1_hit <= '{q: hit.hit_add_inQ, s: hit.hit_add_inS, len: hit.hit_length};
    end
  end

  logic [TABLE_DEPTH-1:0] tab_vld;
  logic [W-1:0]           tab_diag [TABLE_DEPTH];
  logic [W:0]             tab_end  [TABLE_DEPTH];
  logic [TW-1:0]          rep_ptr;

  logic [W-1:0]  diag;
  logic [W:0]    s_end_new;
  logic          match;
  logic [TW-1:0] match_idx;
  logic          free_any;
  logic [TW-1:0] free_idx;
  logic          redundant;
  logic          do_pass;
  logic          do_drop;
  logic [TW-1:0] wr_idx;
  logic [W:0]    wr_end;

  assign diag      = s1_hit.s - s1_hit.q;
  assign s_end_new = {1'b0, s1_hit.s} + {1'b0, s1_hit.len};

  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      if (tab_vld[i] && (tab_diag[i] == diag)) begin
        match     = 1'b1;
        match_idx = TW'(i);
      end
    end
    // Descending scan so the lowest-index free entry wins.
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (!tab_vld[i]) begin
        free_any = 1'b1;
        free_idx = TW'(i);
      end
    end
  end

  assign redundant = match && ({1'b0, s1_hit.s} < tab_end[match_idx]);
  assign do_pass   = s1_vld && !redundant;
  assign do_drop   = s1_vld && redundant;
  assign wr_idx    = match ? match_idx : (free_any ? free_idx : rep_ptr);
  assign wr_end    = (redundant && (tab_end[match_idx] > s_end_new)) ? tab_end[match_idx] : s_end_new;

  always_ff @(posedge com_clk) begin
    if (reset) begin
      tab_vld <= '0;
      rep_ptr <= '0;
    end else if (s1_vld) begin
      tab_vld[wr_idx] <= 1'b1;
      if (!match && !free_any) rep_ptr <= rep_ptr + TW'(1);
    end
  end

  always_ff @(posedge com_clk) begin
    if (s1_vld) begin
      tab_diag[wr_idx] <= diag;
      tab_end[wr_idx]  <= wr_end;
    end
  end

  always_ff @(posedge com_clk) begin
    if (reset) begin
      pass_count <= '0;
      drop_count <= '0;
    end else begin
      if (do_pass && (pass_count != 16'hFFFF)) pass_count <= pass_count + 16'd1;
      if (do_drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

  hit_t head;
  logic fifo_lost;

  sync_fifo #(
    .WIDTH ($bits(hit_t)),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (com_clk),
    .reset   (reset),
    .in_vld  (do_pass),
    .in_dat  (s1_hit),
    .out_vld (hit.out_valid),
    .out_rdy (hit.out_ready),
    .out_dat (head),
    .lost    (fifo_lost)
  );

  assign hit.hit_q_out   = head.q;
  assign hit.hit_s_out   = head.s;
  assign hit.hit_len_out = head.len;

  always_ff @(posedge com_clk) begin
    if (reset)          overflow <= 1'b0;
    else if (fifo_lost) overflow <= 1'b1;
  end
endmodule

// File: tb/tb_hit_diag_filter.sv
// Random and directed stimulus for hit_diag_filter, checked every cycle against a queue-based model.
module tb_hit_diag_filter;
  logic        com_clk = 1'b0;
  logic        reset;
  logic        overflow;
  logic [15:0] pass_count;
  logic [15:0] drop_count;

  hit_diag_filter_if #(.W(8)) hif ();

  hit_diag_filter #(
    .LENGTH_COUNTER (8),
    .TABLE_DEPTH    (8),
    .OUT_DEPTH      (4)
  ) dut (
    .com_clk    (com_clk),
    .reset      (reset),
    .hit        (hif.slave),
    .overflow   (overflow),
    .pass_count (pass_count),
    .drop_count (drop_count)
  );

  always #5 com_clk = ~com_clk;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] s;
    logic [7:0] l;
  } hit_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: table of recent diagonals, FIFO as a queue, one-cycle pending hit.
  hit_t mq[$];
  bit   m_vld [8];
  int   m_diag[8];
  int   m_end [8];
  int   m_ptr;
  bit   m_ovf;
  int   m_pass, m_drop;
  bit   p_vld;
  int   p_q, p_s, p_l;
  bit   chk_en = 1'b0;

  task automatic model_eval();
    int   d, e, idx, slot;
    hit_t h;
    d   = (p_s - p_q) & 255;
    e   = p_s + p_l;
    idx = -1;
    for (int i = 0; i < 8; i++) if (m_vld[i] && m_diag[i] == d) idx = i;
    if (idx >= 0 && p_s < m_end[idx]) begin
      if (m_drop < 65535) m_drop++;
      if (e > m_end[idx]) m_end[idx] = e;
    end else begin
      if (idx >= 0) begin
        m_end[idx] = e;
      end else begin
        slot = -1;
        for (int i = 7; i >= 0; i--) if (!m_vld[i]) slot = i;
        if (slot < 0) begin
          slot  = m_ptr;
          m_ptr = (m_ptr + 1) % 8;
        end
        m_vld[slot]  = 1'b1;
        m_diag[slot] = d;
        m_end[slot]  = e;
      end
      if (m_pass < 65535) m_pass++;
      h = '{q: 8'(p_q), s: 8'(p_s), l: 8'(p_l)};
      if (mq.size() < 4) mq.push_back(h);
      else m_ovf = 1'b1;
    end
  endtask

  always @(posedge com_clk) begin
    if (reset) begin
      mq.delete();
      for (int i = 0; i < 8; i++) m_vld[i] = 1'b0;
      m_ptr  = 0;
      m_ovf  = 1'b0;
      m_pass = 0;
      m_drop = 0;
      p_vld  = 1'b0;
      chk_en = 1'b1;
    end else begin
      if (mq.size() != 0 && hif.out_ready) void'(mq.pop_front());
      if (p_vld) model_eval();
      p_vld = (hif.hit_length != 8'd0);
      p_q   = int'(hif.hit_add_inQ);
      p_s   = int'(hif.hit_add_inS);
      p_l   = int'(hif.hit_length);
    end
  end

  always @(negedge com_clk) begin
    hit_t h;
    if (chk_en) begin
      h = (mq.size() != 0) ? mq[0] : '0;
      chk("out_valid",   32'(hif.out_valid),   32'(mq.size() != 0));
      chk("hit_q_out",   32'(hif.hit_q_out),   32'(h.q));
      chk("hit_s_out",   32'(hif.hit_s_out),   32'(h.s));
      chk("hit_len_out", 32'(hif.hit_len_out), 32'(h.l));
      chk("overflow",    32'(overflow),        32'(m_ovf));
      chk("pass_count",  32'(pass_count),      32'(m_pass));
      chk("drop_count",  32'(drop_count),      32'(m_drop));
    end
  end

  task automatic drive(input logic [7:0] q, input logic [7:0] s, input logic [7:0] l);
    @(posedge com_clk);
    #2;
    hif.hit_add_inQ = q;
    hif.hit_add_inS = s;
    hif.hit_length  = l;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'($urandom), 8'($urandom), 8'd0);
  endtask

  task automatic pulse_reset();
    @(posedge com_clk);
    #2;
    reset          = 1'b1;
    hif.hit_length = 8'd0;
    @(posedge com_clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    hif.hit_add_inQ = 8'd0;
    hif.hit_add_inS = 8'd0;
    hif.hit_length  = 8'd0;
    hif.out_ready   = 1'($urandom);

    // Reset held two cycles with random inputs.
    drive(8'($urandom), 8'($urandom), 8'($urandom));
    drive(8'($urandom), 8'($urandom), 8'($urandom));
    reset          = 1'b0;
    hif.hit_length = 8'd0;
    @(negedge com_clk);
    chk("rst_valid", 32'(hif.out_valid), 32'd0);
    chk("rst_q",     32'(hif.hit_q_out), 32'd0);
    chk("rst_pass",  32'(pass_count),    32'd0);
    chk("rst_drop",  32'(drop_count),    32'd0);
    chk("rst_ovf",   32'(overflow),      32'd0);

    // Single hit: visible two cycles later.
    hif.out_ready = 1'b1;
    drive(8'h10, 8'h20, 8'd5);
    idle(1);
    @(negedge com_clk);
    chk("lat_k1_valid", 32'(hif.out_valid), 32'd0);
    @(negedge com_clk);
    chk("lat_k2_valid", 32'(hif.out_valid),   32'd1);
    chk("lat_k2_q",     32'(hif.hit_q_out),   32'h10);
    chk("lat_k2_s",     32'(hif.hit_s_out),   32'h20);
    chk("lat_k2_len",   32'(hif.hit_len_out), 32'd5);
    chk("lat_k2_pass",  32'(pass_count),      32'd1);

    // Redundancy on diagonal 0x10; 0x25 < 0x26 proves the max() extension.
    drive(8'h12, 8'h22, 8'd4); idle(2);
    @(negedge com_clk); chk("red1_drop", 32'(drop_count), 32'd1);
    drive(8'h15, 8'h25, 8'd1); idle(2);
    @(negedge com_clk); chk("red2_drop", 32'(drop_count), 32'd2);
    drive(8'h17, 8'h27, 8'd3); idle(2);
    @(negedge com_clk); chk("red3_pass", 32'(pass_count), 32'd2);

    // Back-to-back same diagonal.
    drive(8'h00, 8'h05, 8'd8);
    drive(8'h01, 8'h06, 8'd2);
    idle(2);
    @(negedge com_clk);
    chk("b2b_pass", 32'(pass_count), 32'd3);
    chk("b2b_drop", 32'(drop_count), 32'd3);

    // Diagonal wraps mod 256: 0x10 - 0xF0 = 0x20; S equal to s_end passes.
    drive(8'hF0, 8'h10, 8'd1); idle(1);
    @(negedge com_clk); @(negedge com_clk);
    chk("wrap_q", 32'(hif.hit_q_out), 32'hF0);
    drive(8'hF1, 8'h11, 8'd1); idle(2);
    @(negedge com_clk); chk("wrap_eq_pass", 32'(pass_count), 32'd5);
    drive(8'hF0, 8'h10, 8'd1); idle(2);
    @(negedge com_clk); chk("wrap_drop", 32'(drop_count), 32'd4);

    // Reset with a hit in flight: it must vanish.
    drive(8'h33, 8'h44, 8'd2);
    pulse_reset();
    @(negedge com_clk);
    chk("midrst_pass",  32'(pass_count),    32'd0);
    chk("midrst_valid", 32'(hif.out_valid), 32'd0);

    // Nine diagonals evict the first; it then passes again.
    for (int i = 0; i < 9; i++) drive(8'(i), 8'h80, 8'd4);
    idle(3);
    @(negedge com_clk); chk("evict9_pass", 32'(pass_count), 32'd9);
    drive(8'h00, 8'h80, 8'd4); idle(2);
    @(negedge com_clk);
    chk("evict_rep_pass", 32'(pass_count), 32'd10);
    chk("evict_rep_drop", 32'(drop_count), 32'd0);
    drive(8'h03, 8'h81, 8'd1); idle(2);
    @(negedge com_clk); chk("survivor_drop", 32'(drop_count), 32'd1);

    // Backpressure: six passes into a 4-deep FIFO.
    pulse_reset();
    hif.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive(8'(i), 8'h60, 8'd2);
    idle(3);
    @(negedge com_clk);
    chk("bp_valid", 32'(hif.out_valid), 32'd1);
    chk("bp_ovf",   32'(overflow),      32'd1);
    chk("bp_pass",  32'(pass_count),    32'd6);
    @(posedge com_clk);
    #2;
    hif.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge com_clk);
      chk("bp_pop_q",     32'(hif.hit_q_out), 32'(j));
      chk("bp_pop_valid", 32'(hif.out_valid), 32'd1);
    end
    @(negedge com_clk);
    chk("bp_empty", 32'(hif.out_valid), 32'd0);

    // Random traffic over a few diagonals, with wrap-around regions and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] q;
      @(posedge com_clk);
      #2;
      reset         = ($urandom_range(0, 299) == 0);
      hif.out_ready = (((n / 64) % 4) == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      q             = 8'($urandom_range(0, 15) + ((((n / 500) % 2) == 1) ? 240 : 0));
      hif.hit_add_inQ = q;
      hif.hit_add_inS = q + 8'($urandom_range(0, 11) * 3) + 8'($urandom_range(0, 7));
      hif.hit_length  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
    end
    reset         = 1'b0;
    hif.out_ready = 1'b1;
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
